// File: rtl/sampler_pkg.sv
// Shared types and constants for the weighted sampler: data width, FSM states,
// LFSR feedback mask and seed sanitising.
package sampler_pkg;

  localparam int DATA_W = 40;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SUM,
    ST_REQ,
    ST_WAIT,
    ST_SCAN,
    ST_FIN
  } state_t;

  // Taps 40,38,21,19 for the right-shifting Galois form.
  localparam logic [DATA_W-1:0] LFSR_TAPS = 40'hA0_0014_0000;

  // An all-zero LFSR would lock up, so a zero seed becomes 1.
  function automatic logic [DATA_W-1:0] seed_fix(input logic [DATA_W-1:0] s);
    return (s == '0) ? {{(DATA_W-1){1'b0}}, 1'b1} : s;
  endfunction

endpackage

// File: rtl/lfsr40_galois.sv
// Step-enabled 40-bit Galois LFSR; nxt is the value the register takes on the next step.
module lfsr40_galois
  import sampler_pkg::*;
#(
  parameter logic [DATA_W-1:0] SEED = 40'h00_DEAD_BEEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  output logic [DATA_W-1:0] nxt
);

  logic [DATA_W-1:0] q;

  assign nxt = (q >> 1) ^ (q[0] ? LFSR_TAPS : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= seed_fix(SEED);
    else if (step) q <= nxt;
  end

endmodule

// File: rtl/weighted_sampler.sv
// Draws one class index from an unnormalised weight table using an external
// modulo stage: sum weights, request random % sum, then scan cumulative weights.
module weighted_sampler
  import sampler_pkg::*;
#(
  parameter int               N_CLASS = 128,
  parameter int               IDX_W   = 7,
  parameter logic [DATA_W-1:0] SEED   = 40'h00_DEAD_BEEF,
  parameter int               TIMEOUT = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [IDX_W-1:0]  wt_addr,
  input  logic [DATA_W-1:0] wt_data,
  output logic              mod_en,
  output logic [DATA_W-1:0] mod_in0,
  output logic [DATA_W-1:0] mod_in1,
  input  logic              mod_valid,
  input  logic [DATA_W-1:0] mod_out,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  idx,
  output logic              err
);

  localparam int               CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(N_CLASS - 1);

  state_t            state;
  logic [1:0]        vld_pipe;   // [0]: wt_addr is a live read, [1]: wt_data is live
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_nxt;
  logic [DATA_W-1:0] rem;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] lfsr_nxt;

  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DATA_W] ? '1 : s[DATA_W-1:0];
  endfunction

  assign acc_nxt = sat_add(acc, wt_data);

  lfsr40_galois #(.SEED(SEED)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .step (state == ST_REQ),
    .nxt  (lfsr_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      vld_pipe <= '0;
      rd_idx   <= '0;
      wt_addr  <= '0;
      acc      <= '0;
      rem      <= '0;
      cnt      <= '0;
      mod_en   <= 1'b0;
      mod_in0  <= '0;
      mod_in1  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      idx      <= '0;
      err      <= 1'b0;
    end else begin
      mod_en      <= 1'b0;
      vld_pipe[1] <= vld_pipe[0];
      rd_idx      <= wt_addr;
      if (vld_pipe[0]) begin
        if (wt_addr == LAST) vld_pipe[0] <= 1'b0;
        else                 wt_addr     <= wt_addr + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_SUM;
            busy        <= 1'b1;
            acc         <= '0;
            wt_addr     <= '0;
            vld_pipe[0] <= 1'b1;
          end
        end

        ST_SUM: begin
          if (vld_pipe[1]) begin
            acc <= acc_nxt;
            if (rd_idx == LAST) begin
              if (acc_nxt == '0) begin
                state <= ST_FIN;
                done  <= 1'b1;
                err   <= 1'b1;
                idx   <= '0;
              end else begin
                state <= ST_REQ;
              end
            end
          end
        end

        ST_REQ: begin
          mod_in0 <= lfsr_nxt;
          mod_in1 <= acc;
          mod_en  <= 1'b1;
          cnt     <= '0;
          state   <= ST_WAIT;
        end

        ST_WAIT: begin
          if (mod_valid) begin
            rem         <= mod_out;
            acc         <= '0;
            wt_addr     <= '0;
            vld_pipe[0] <= 1'b1;
            state       <= ST_SCAN;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state <= ST_FIN;
            done  <= 1'b1;
            err   <= 1'b1;
            idx   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_SCAN: begin
          if (vld_pipe[1]) begin
            acc <= acc_nxt;
            // Zero weights never raise the cumulative sum, so they can never be the first hit.
            if (rem < acc_nxt) begin
              vld_pipe[0] <= 1'b0;
              idx         <= rd_idx;
              err         <= 1'b0;
              done        <= 1'b1;
              state       <= ST_FIN;
            end else if (rd_idx == LAST) begin
              idx   <= LAST;
              err   <= 1'b1;
              done  <= 1'b1;
              state <= ST_FIN;
            end
          end
        end

        ST_FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weighted_sampler.sv
// Randomised bench for weighted_sampler with a RAM model, a modulo-stage model and
// an arithmetic reference for the LFSR sequence and cumulative-weight selection.
module tb_weighted_sampler;
  localparam int          N       = 4;
  localparam int          IW      = 2;
  localparam int          TMO     = 16;
  localparam logic [39:0] SEED    = 40'h1;
  localparam logic [39:0] MAXV    = 40'hFF_FFFF_FFFF;
  localparam int          BUDGET  = 300;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [IW-1:0] wt_addr;
  logic [39:0]   wt_data;
  logic          mod_en;
  logic [39:0]   mod_in0, mod_in1;
  logic          mod_valid = 1'b0;
  logic [39:0]   mod_out = '0;
  logic          busy, done, err;
  logic [IW-1:0] idx;

  weighted_sampler #(.N_CLASS(N), .IDX_W(IW), .SEED(SEED), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .wt_addr(wt_addr), .wt_data(wt_data),
    .mod_en(mod_en), .mod_in0(mod_in0), .mod_in1(mod_in1), .mod_valid(mod_valid),
    .mod_out(mod_out), .busy(busy), .done(done), .idx(idx), .err(err)
  );

  always #5 clk = ~clk;

  logic [39:0] wts [N];
  always @(posedge clk) wt_data <= wts[wt_addr];

  int n_chk = 0, n_fail = 0;
  logic [39:0] m_lfsr = SEED;

  // results of the last run
  int          en_cnt, en_at, done_at;
  logic [39:0] got_in0, got_in1;
  logic [IW-1:0] got_idx;
  logic        got_err, busy1, busy_after;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] lfsr_step(input logic [39:0] x);
    logic [39:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ 40'hA0_0014_0000;
    return y;
  endfunction

  // mode 0: modulo stage computes the remainder, 1: forced remainder fr, 2: never answers
  task automatic run_sample(input int mode, input logic [39:0] fr, input int lat, input bit restart);
    int cd;
    cd = -1; en_cnt = 0; en_at = -1; done_at = -1; busy1 = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= BUDGET; c++) begin
      mod_valid = 1'b0;
      if (c == 1) busy1 = busy;
      if (mod_en) begin
        en_cnt++; got_in0 = mod_in0; got_in1 = mod_in1; en_at = c;
        if (mode != 2) cd = lat;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          mod_valid = 1'b1;
          mod_out = (mode == 1) ? fr : ((mod_in1 != 0) ? mod_in0 % mod_in1 : '0);
        end
      end
      start = (restart && c == 5);
      if (done) begin
        done_at = c; got_idx = idx; got_err = err;
        break;
      end
      @(negedge clk);
    end
    mod_valid = 1'b0; start = 1'b0;
    @(negedge clk);
    busy_after = busy;
  endtask

  task automatic do_sample(input string tag, input int mode, input logic [39:0] fr,
                           input int lat, input bit restart);
    longint unsigned tot, c, r;
    logic [39:0] sum, e0;
    int eidx; bit eerr, een;
    tot = 0;
    for (int i = 0; i < N; i++) tot += wts[i];
    sum = (tot > MAXV) ? MAXV : tot[39:0];
    een = (sum != 0); e0 = '0; eidx = 0; eerr = 1'b1;
    if (een) begin
      m_lfsr = lfsr_step(m_lfsr);
      e0 = m_lfsr;
      if (mode != 2) begin
        r = (mode == 1) ? fr : (e0 % sum);
        c = 0; eidx = N - 1;
        for (int i = 0; i < N; i++) begin
          c += wts[i];
          if (r < ((c > MAXV) ? MAXV : c)) begin eidx = i; eerr = 1'b0; break; end
        end
      end
    end
    run_sample(mode, fr, lat, restart);
    chk({tag, ".done_seen"}, done_at > 0, 1);
    chk({tag, ".en_cnt"}, en_cnt, een);
    if (een) begin
      chk({tag, ".mod_in0"}, got_in0, e0);
      chk({tag, ".mod_in1"}, got_in1, sum);
    end
    chk({tag, ".idx"}, got_idx, eidx);
    chk({tag, ".err"}, got_err, eerr);
    chk({tag, ".busy_run"}, busy1, 1);
    chk({tag, ".busy_after"}, busy_after, 0);
    if (een && mode == 2)
      chk({tag, ".timeout"}, done_at - en_at, TMO);
    else if (een) begin
      int d;
      d = done_at - (N + lat + eidx + 5);
      chk({tag, ".latency"}, (d >= -1 && d <= 1), 1);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) wts[i] = '0;
    repeat (2) @(negedge clk);
    chk("reset.outs", {wt_addr, mod_en, mod_in0, mod_in1, busy, done, idx, err}, '0);
    rst = 1'b0;
    @(negedge clk);

    wts[0] = 1; wts[1] = 2; wts[2] = 3; wts[3] = 4;
    do_sample("w1234_r0", 1, 40'd0, 2, 1'b0);
    do_sample("w1234_r2", 1, 40'd2, 1, 1'b0);
    chk("seed1.second_in0", got_in0, 40'h50_000A_0000);
    do_sample("w1234_r9", 1, 40'd9, 3, 1'b1);
    do_sample("w1234_r10", 1, 40'd10, 1, 1'b0);

    wts[0] = 0; wts[1] = 0; wts[2] = 5; wts[3] = 0;
    do_sample("w0050", 0, '0, 2, 1'b0);
    chk("w0050.idx_is2", got_idx, 2);

    for (int i = 0; i < N; i++) wts[i] = '0;
    do_sample("allzero", 0, '0, 1, 1'b0);

    wts[0] = 7; wts[1] = 0; wts[2] = 9; wts[3] = 1;
    do_sample("timeout", 2, '0, 1, 1'b0);

    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < N; i++) begin
        int p;
        p = $urandom_range(0, 9);
        if (p < 3)      wts[i] = '0;
        else if (p < 8) wts[i] = 40'($urandom_range(1, 1000));
        else            wts[i] = {8'($urandom), 32'($urandom)};
      end
      do_sample($sformatf("rand%0d", t), 0, '0, $urandom_range(1, 6), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of WAIT, then a stale remainder arriving afterwards.
    wts[0] = 3; wts[1] = 1; wts[2] = 4; wts[3] = 1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < BUDGET && !mod_en; c++) @(negedge clk);
    chk("rstwait.en_seen", mod_en, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1; m_lfsr = SEED;
    #1;
    chk("rstwait.outs", {wt_addr, mod_en, mod_in0, mod_in1, busy, done, idx, err}, '0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    mod_valid = 1'b1; mod_out = 40'd2;
    @(negedge clk); mod_valid = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 12; c++) begin
        if (done || busy) seen++;
        @(negedge clk);
      end
      chk("rstwait.quiet", seen, 0);
    end
    do_sample("after_rst", 0, '0, 2, 1'b0);
    chk("after_rst.first_step", got_in0, 40'hA0_0014_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/weighted_sampler.md
# weighted_sampler

Draws one class index from an unnormalised weight table (e.g. note probabilities produced by the output layer) for the composer's note-generation loop. Sums the weights, produces a 40-bit pseudo-random value, sends the value and the weight total to the downstream modulo stage, takes back the remainder, and scans the cumulative weights to select the index. It sits directly upstream of the modulo stage and drives that stage's operand and enable inputs.

## Interface
- N_CLASS, 128, number of weight entries / selectable indices
- IDX_W, 7, index width, equal to clog2(N_CLASS)
- SEED, 40'h00_DEAD_BEEF, LFSR reset value; a value of 0 is replaced by 1
- TIMEOUT, 128, maximum number of cycles to wait for mod_valid
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request for a sample; ignored while busy
- wt_addr  out  IDX_W  weight RAM read address
- wt_data  in  40  weight RAM data, valid 1 cycle after wt_addr
- mod_en  out  1  one-cycle operand strobe to the modulo stage
- mod_in0  out  40  dividend: random value
- mod_in1  out  40  divisor: weight total
- mod_valid  in  1  remainder valid from the modulo stage
- mod_out  in  40  remainder, equal to mod_in0 % mod_in1
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle completion pulse
- idx  out  IDX_W  selected index; held from done until the next done
- err  out  1  status of the last sample; valid with done and held

## Operation
- States: IDLE, SUM, REQ, WAIT, SCAN, FIN.
- **IDLE:** start=1 moves to SUM and clears the accumulator.
- **SUM:**
  - Issue wt_addr 0..N_CLASS-1 on consecutive cycles.
  - Accumulate each returned wt_data into the 40-bit sum. The sum saturates at all-ones and never wraps.
  - After the last data word: sum==0 goes to FIN with err=1 and idx=0, and no mod_en is issued. Otherwise go to REQ.
- **REQ:**
  - Step the LFSR once.
  - Drive mod_in0=new LFSR value, mod_in1=sum, mod_en=1 for exactly one cycle.
  - mod_in0 and mod_in1 hold stable until the state leaves WAIT.
- **WAIT:**
  - mod_valid=1: latch r=mod_out and go to SCAN.
  - A cycle counter reaching TIMEOUT goes to FIN with err=1 and idx=0.
  - mod_valid outside WAIT is ignored.
- **SCAN:**
  - Reissue addresses 0..N-1. Cumulative c += wt_data.
  - The first i with r < c (unsigned) sets idx=i, err=0, then go to FIN. Stop issuing addresses once a hit is found.
  - Zero-weight entries are never selected.
  - If no hit after N-1 (r >= sum, malformed remainder): idx=N_CLASS-1, err=1.
- **FIN:** done=1 for one cycle, then IDLE.
- **LFSR:**
  - 40-bit Galois, right-shift form: lsb=x[0]; x=x>>1; if lsb, x ^= 40'hA0_0014_0000 (taps 40,38,21,19).
  - It steps only in REQ, so the sample sequence is deterministic from SEED.

## Timing
- Reset values: wt_addr=0, mod_en=0, mod_in0=0, mod_in1=0, busy=0, done=0, idx=0, err=0, state=IDLE, LFSR=SEED.
- Reset mid-operation aborts immediately. No done is produced. A late mod_valid after reset is ignored.
- start is sampled at cycle T.
  - SUM addresses run on T+1..T+N; data returns on T+2..T+N+1.
  - REQ is at T+N+2.
  - WAIT lasts L_mod cycles, where L_mod is the modulo-stage latency.
  - SCAN takes k+2 cycles for a hit at index k.
  - FIN produces done.
- Total latency is N + L_mod + k + 5 cycles (±1 depending on the exact sequencing).
- start together with done: start is ignored, because the block is not yet in IDLE.

## Structure
- Package sampler_pkg holds:
  - the 40-bit data width constant,
  - the state enum,
  - the LFSR tap-mask constant,
  - the zero-seed substitution function.
- One sub-module, lfsr40_galois: a step-enabled Galois LFSR with a seed parameter.
- The modulo stage is instantiated by the parent, not inside this block.

## Test plan
- N=4, weights [1,2,3,4]: mod_in1=10 with one mod_en pulse. Model mod_out=0 → idx=0; 2 → idx=1; 9 → idx=3. err=0 in all three cases.
- Weights [0,0,5,0], any r<5 → idx=2, err=0. mod_in1=5.
- All weights 0 → done with err=1, idx=0. mod_en is never asserted.
- SEED=1, two consecutive samples → mod_in0=40'hA0_0014_0000, then 40'h50_000A_0000.
- mod_valid withheld → done exactly TIMEOUT cycles after entering WAIT, with err=1. busy drops the cycle after done.
- rst pulsed during WAIT → all outputs 0 that cycle, no done. A mod_valid arriving 3 cycles later is ignored. The next sample's mod_in0 is the first LFSR step from SEED.
